// File: rtl/hc_sr04_distance_filter.sv
// Smooths strobed HC-SR04 distance samples with a 4-sample moving average,
// derives a hysteretic near flag and flags loss of echo after a sample timeout.
module hc_sr04_distance_filter #(
    parameter int unsigned clk_frequency  = 50_000_000,
    parameter int unsigned timeout_ms     = 100,
    parameter int unsigned near_threshold = 40,
    parameter int unsigned far_threshold  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] distance_in,
    input  logic       distance_valid,
    output logic [7:0] avg_distance,
    output logic       avg_strobe,
    output logic       avg_valid,
    output logic       near,
    output logic       no_echo
);

    localparam logic [31:0] TIMEOUT_CYCLES = 32'(timeout_ms * (clk_frequency / 1000));
    localparam logic [7:0]  NEAR_TH        = 8'(near_threshold);
    localparam logic [7:0]  FAR_TH         = 8'(far_threshold);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_LOST
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_buf [4];
    logic [9:0]  r_sum;
    logic [1:0]  r_fill_cnt;
    logic [31:0] r_tcnt;

    logic        w_accept;
    logic        w_timeout;
    logic        w_fill_done;
    logic        w_publish;
    logic        w_enter_lost;
    logic [9:0]  w_sum_next;
    logic [7:0]  w_avg_next;

    function automatic logic f_near(input logic [7:0] avg, input logic cur);
        if (avg <= NEAR_TH) begin
            return 1'b1;
        end else if (avg >= FAR_TH) begin
            return 1'b0;
        end
        return cur;
    endfunction

    function automatic logic [31:0] f_tcnt_sat(input logic [31:0] cnt);
        if (cnt < TIMEOUT_CYCLES) begin
            return cnt + 32'd1;
        end
        return TIMEOUT_CYCLES;
    endfunction

    // Zero readings mean "no echo measured" upstream and are not samples.
    assign w_accept     = distance_valid && (distance_in != 8'd0);
    assign w_timeout    = !w_accept && (r_state != ST_LOST)
                          && ((r_tcnt + 32'd1) >= TIMEOUT_CYCLES);
    assign w_sum_next   = r_sum + {2'b00, distance_in} - {2'b00, r_buf[3]};
    assign w_avg_next   = w_sum_next[9:2];
    assign w_fill_done  = (r_state == ST_FILL) && w_accept && (r_fill_cnt == 2'd3);
    assign w_publish    = w_accept && ((r_state == ST_RUN) || w_fill_done);
    assign w_enter_lost = (w_state_next == ST_LOST) && (r_state != ST_LOST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_fill_done) begin
                    w_state_next = ST_RUN;
                end else if (w_timeout) begin
                    w_state_next = ST_LOST;
                end
            end
            ST_RUN: begin
                if (w_timeout) begin
                    w_state_next = ST_LOST;
                end
            end
            ST_LOST: begin
                if (w_accept) begin
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= 8'd0;
            end
            r_sum        <= 10'd0;
            r_fill_cnt   <= 2'd0;
            r_tcnt       <= 32'd0;
            avg_distance <= 8'd0;
            avg_strobe   <= 1'b0;
            avg_valid    <= 1'b0;
            near         <= 1'b0;
            no_echo      <= 1'b0;
        end else begin
            avg_strobe <= w_publish;
            no_echo    <= (w_state_next == ST_LOST);
            r_tcnt     <= w_accept ? 32'd0 : f_tcnt_sat(r_tcnt);

            if (w_enter_lost) begin
                // avg_distance deliberately keeps its last value for the display.
                for (int i = 0; i < 4; i++) begin
                    r_buf[i] <= 8'd0;
                end
                r_sum      <= 10'd0;
                r_fill_cnt <= 2'd0;
                avg_valid  <= 1'b0;
                near       <= 1'b0;
            end else if (w_accept) begin
                r_buf[0] <= distance_in;
                r_buf[1] <= r_buf[0];
                r_buf[2] <= r_buf[1];
                r_buf[3] <= r_buf[2];
                r_sum    <= w_sum_next;

                if (r_state == ST_LOST) begin
                    r_fill_cnt <= 2'd1;
                end else if (r_state == ST_FILL) begin
                    r_fill_cnt <= r_fill_cnt + 2'd1;
                end

                if (w_publish) begin
                    avg_distance <= w_avg_next;
                    near         <= f_near(w_avg_next, near);
                    avg_valid    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hc_sr04_distance_filter.sv
// Directed bench for hc_sr04_distance_filter: fill, moving window, hysteresis,
// zero rejection, timeout/recovery, timeout tie and mid-fill reset.
module tb_hc_sr04_distance_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] distance_in;
    logic       distance_valid;
    logic [7:0] avg_distance;
    logic       avg_strobe;
    logic       avg_valid;
    logic       near;
    logic       no_echo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hc_sr04_distance_filter #(
        .clk_frequency (1_000_000),
        .timeout_ms    (1),
        .near_threshold(40),
        .far_threshold (60)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .distance_in   (distance_in),
        .distance_valid(distance_valid),
        .avg_distance  (avg_distance),
        .avg_strobe    (avg_strobe),
        .avg_valid     (avg_valid),
        .near          (near),
        .no_echo       (no_echo)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called at a falling edge; the sample is captured on the next rising edge
    // and the task returns at the falling edge right after it.
    task automatic send(input logic [7:0] v);
        distance_in    = v;
        distance_valid = 1'b1;
        @(negedge clk);
        distance_valid = 1'b0;
        distance_in    = 8'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] win_in   [13] = '{8'd100, 8'd80, 8'd80, 8'd80, 8'd80, 8'd50, 8'd50,
                                  8'd30, 8'd30, 8'd130, 8'd10, 8'd10, 8'd10};
    logic [7:0] win_avg  [13] = '{8'd47, 8'd62, 8'd75, 8'd85, 8'd80, 8'd72, 8'd65,
                                  8'd52, 8'd40, 8'd60, 8'd50, 8'd45, 8'd40};
    logic       win_near [13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] fill_in  [4]  = '{8'd10, 8'd20, 8'd30, 8'd40};

    initial begin
        rst            = 1'b1;
        distance_in    = 8'd0;
        distance_valid = 1'b0;
        idle(3);
        check("rst_avg", 32'(avg_distance), 0);
        check("rst_strobe", 32'(avg_strobe), 0);
        check("rst_valid", 32'(avg_valid), 0);
        check("rst_near", 32'(near), 0);
        check("rst_no_echo", 32'(no_echo), 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(49);
            send(fill_in[i]);
            if (i < 3) begin
                check("fill_strobe", 32'(avg_strobe), 0);
                check("fill_valid", 32'(avg_valid), 0);
            end
        end
        check("fill4_strobe", 32'(avg_strobe), 1);
        check("fill4_valid", 32'(avg_valid), 1);
        check("fill4_avg", 32'(avg_distance), 25);
        check("fill4_near", 32'(near), 1);
        idle(1);
        check("fill4_strobe_width", 32'(avg_strobe), 0);

        for (int i = 0; i < 13; i++) begin
            idle(4);
            send(win_in[i]);
            check("win_strobe", 32'(avg_strobe), 1);
            check("win_avg", 32'(avg_distance), 32'(win_avg[i]));
            check("win_near", 32'(near), 32'(win_near[i]));
        end

        send(8'd0);
        check("zero_strobe", 32'(avg_strobe), 0);
        check("zero_avg", 32'(avg_distance), 40);
        check("zero_valid", 32'(avg_valid), 1);
        idle(998);
        check("pre_timeout_no_echo", 32'(no_echo), 0);
        check("pre_timeout_near", 32'(near), 1);
        idle(1);
        check("lost_no_echo", 32'(no_echo), 1);
        check("lost_valid", 32'(avg_valid), 0);
        check("lost_near", 32'(near), 0);
        check("lost_avg_hold", 32'(avg_distance), 40);

        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(2);
            send(8'd200);
            check("recov_no_echo", 32'(no_echo), 0);
            if (i < 3) begin
                check("recov_strobe", 32'(avg_strobe), 0);
                check("recov_valid", 32'(avg_valid), 0);
            end
        end
        check("recov_strobe4", 32'(avg_strobe), 1);
        check("recov_valid4", 32'(avg_valid), 1);
        check("recov_avg", 32'(avg_distance), 200);
        check("recov_near", 32'(near), 0);

        idle(999);
        check("tie_pre_no_echo", 32'(no_echo), 0);
        send(8'd210);
        check("tie_no_echo", 32'(no_echo), 0);
        check("tie_strobe", 32'(avg_strobe), 1);
        check("tie_avg", 32'(avg_distance), 202);
        idle(1);
        check("tie_after_no_echo", 32'(no_echo), 0);

        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_avg", 32'(avg_distance), 0);
        check("midrst_valid", 32'(avg_valid), 0);
        check("midrst_no_echo", 32'(no_echo), 0);
        send(8'd50);
        idle(2);
        send(8'd50);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("fillrst_valid", 32'(avg_valid), 0);
        check("fillrst_avg", 32'(avg_distance), 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(2);
            send(8'd60);
            if (i < 3) begin
                check("refill_strobe", 32'(avg_strobe), 0);
                check("refill_valid", 32'(avg_valid), 0);
            end
        end
        check("refill_strobe4", 32'(avg_strobe), 1);
        check("refill_valid4", 32'(avg_valid), 1);
        check("refill_avg", 32'(avg_distance), 60);
        check("refill_near", 32'(near), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
